// File: rtl/demux_pkg.sv
// Shared select encoding and channel count for the 1-to-3 stream demultiplexer.
package demux_pkg;

  typedef enum logic [1:0] {
    SEL_Y1   = 2'b00,
    SEL_Y2   = 2'b01,
    SEL_Y3   = 2'b10,
    SEL_DROP = 2'b11
  } sel_t;

  localparam int NUM_CH = 3;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with valid/ready; accepts a new word in the same
// cycle the held word drains, so a channel sustains one word per clock.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             can_load
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux3_stream.sv
// 1-to-3 stream demultiplexer: steers each accepted word to one of three
// registered channels by s, or discards it (s=11) and counts the drop.
module demux3_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             y1_valid,
  output logic             y2_valid,
  output logic             y3_valid,
  input  logic             y1_ready,
  input  logic             y2_ready,
  input  logic             y3_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_valid, ch_ready, ch_load, ch_can_load;
  sel_t                         sel;
  logic                         xfer;

  assign sel      = sel_t'(s);
  assign ch_ready = {y3_ready, y2_ready, y1_ready};

  // Only the selected channel gates acceptance; drops are always accepted.
  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_Y1:   in_ready = ch_can_load[0];
      SEL_Y2:   in_ready = ch_can_load[1];
      SEL_Y3:   in_ready = ch_can_load[2];
      default:  in_ready = 1'b1;
    endcase
  end

  assign xfer = in_valid && in_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign ch_load[i] = xfer && (s == 2'(i));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (ch_load[i]),
      .in_data   (in_data),
      .out_ready (ch_ready[i]),
      .out_data  (ch_data[i]),
      .out_valid (ch_valid[i]),
      .can_load  (ch_can_load[i])
    );
  end

  assign y1       = ch_data[0];
  assign y2       = ch_data[1];
  assign y3       = ch_data[2];
  assign y1_valid = ch_valid[0];
  assign y2_valid = ch_valid[1];
  assign y3_valid = ch_valid[2];

  // Saturating drop counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (xfer && sel == SEL_DROP && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux3_stream.sv
// Bench for demux3_stream: directed scenarios plus random traffic, checked every
// cycle against a queue-based channel model.
module tb_demux3_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic [1:0] s = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] y1, y2, y3, drop_cnt;
  logic       y1_valid, y2_valid, y3_valid;
  logic [2:0] rdy = 3'b111;

  int tests = 0;
  int fails = 0;

  demux3_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .y1(y1), .y2(y2), .y3(y3),
    .y1_valid(y1_valid), .y2_valid(y2_valid), .y3_valid(y3_valid),
    .y1_ready(rdy[0]), .y2_ready(rdy[1]), .y3_ready(rdy[2]), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] ydat [3];
  logic       yv   [3];
  assign ydat[0] = y1; assign ydat[1] = y2; assign ydat[2] = y3;
  assign yv[0] = y1_valid; assign yv[1] = y2_valid; assign yv[2] = y3_valid;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a queue of words awaiting the consumer; the head is
  // what the consumer sees. last_d remembers the most recent word for data hold.
  logic [7:0] q [3][$];
  logic [7:0] last_d [3];
  int         m_drop = 0;
  bit         model_on = 0;

  function automatic bit m_in_ready();
    if (s == 2'b11) return 1'b1;
    if (q[int'(s)].size() == 0) return 1'b1;
    return rdy[int'(s)];
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        q[c].delete();
        last_d[c] = 8'h00;
      end
      m_drop   = 0;
      model_on = 1;
    end else begin
      acc = in_valid && m_in_ready();
      for (int c = 0; c < 3; c++)
        if (q[c].size() > 0 && rdy[c]) void'(q[c].pop_front());
      if (acc) begin
        if (s == 2'b11) begin
          if (m_drop < 255) m_drop++;
        end else begin
          q[int'(s)].push_back(in_data);
          last_d[int'(s)] = in_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("y%0d_valid", c + 1), int'(yv[c]), int'(q[c].size() > 0));
        if (q[c].size() > 0)
          check($sformatf("y%0d_data", c + 1), int'(ydat[c]), int'(q[c][0]));
        else
          check($sformatf("y%0d_hold", c + 1), int'(ydat[c]), int'(last_d[c]));
      end
      check("in_ready", int'(in_ready), int'(m_in_ready()));
      check("drop_cnt", int'(drop_cnt), m_drop);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] d);
    in_valid = 1'b1;
    s        = sel;
    in_data  = d;
  endtask

  initial begin
    // 1: reset then idle
    cyc(); cyc();
    reset = 1'b0;
    check("rst_y1v", int'(y1_valid), 0);
    check("rst_y2v", int'(y2_valid), 0);
    check("rst_y3v", int'(y3_valid), 0);
    check("rst_y1", int'(y1), 0);
    check("rst_drop", int'(drop_cnt), 0);
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      #1;
      check("idle_in_ready", int'(in_ready), 1);
    end
    cyc();

    // 2: one word per channel on consecutive cycles
    rdy = 3'b111;
    send(2'b00, 8'hFF); cyc();
    check("t2_y1", int'(y1), 'hFF); check("t2_y1v", int'(y1_valid), 1);
    send(2'b01, 8'h0F); cyc();
    check("t2_y2", int'(y2), 'h0F); check("t2_y1v_off", int'(y1_valid), 0);
    send(2'b10, 8'h33); cyc();
    check("t2_y3", int'(y3), 'h33); check("t2_y3v", int'(y3_valid), 1);
    in_valid = 1'b0; cyc();

    // 3: stall y2 with back-to-back reload on drain
    rdy[1] = 1'b0;
    send(2'b01, 8'hA5); cyc();
    check("t3_y2", int'(y2), 'hA5);
    send(2'b01, 8'h5A); #1;
    check("t3_blocked", int'(in_ready), 0);
    cyc();
    check("t3_hold", int'(y2), 'hA5);
    rdy[1] = 1'b1; #1;
    check("t3_unblocked", int'(in_ready), 1);
    cyc();
    check("t3_reload", int'(y2), 'h5A); check("t3_y2v", int'(y2_valid), 1);
    in_valid = 1'b0; cyc();

    // 4: a stalled y1 must not block y3
    rdy[0] = 1'b0;
    send(2'b00, 8'h11); cyc();
    send(2'b10, 8'h3C); #1;
    check("t4_in_ready", int'(in_ready), 1);
    cyc();
    check("t4_y3", int'(y3), 'h3C); check("t4_y1", int'(y1), 'h11);
    in_valid = 1'b0; rdy = 3'b111; cyc();

    // 5: drop counter saturates
    for (int k = 0; k < 300; k++) begin
      send(2'b11, 8'(k)); cyc();
    end
    check("t5_drop_sat", int'(drop_cnt), 255);
    in_valid = 1'b0;

    // 6: reset while y1,y3 hold stalled words
    rdy = 3'b000;
    send(2'b00, 8'h44); cyc();
    send(2'b10, 8'h77); cyc();
    send(2'b01, 8'h99); reset = 1'b1; cyc();
    reset = 1'b0; in_valid = 1'b0;
    check("t6_y1v", int'(y1_valid), 0);
    check("t6_y2v", int'(y2_valid), 0);
    check("t6_y3v", int'(y3_valid), 0);
    check("t6_drop", int'(drop_cnt), 0);
    rdy = 3'b111;
    send(2'b10, 8'hC3); cyc();
    check("t6_new", int'(y3), 'hC3);
    in_valid = 1'b0; cyc();

    // random traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      s        = 2'($urandom_range(0, 3));
      in_data  = 8'($urandom);
      rdy      = 3'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0; in_valid = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
